// File: rtl/axi_full_m_line_if.sv
// rtl/axi_full_m_line_if.sv - AXI4 full bus bundle between the line master and the memory slave
interface axi_full_m_line_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [1:0]  arburst;
    logic [7:0]  arlen;
    logic [2:0]  arsize;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [1:0]  awburst;
    logic [7:0]  awlen;

    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;

    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, arburst, arlen, arsize,
        output awaddr, awvalid, awburst, awlen,
        output rready, wdata, wstrb, wlast, wvalid, bready,
        input  arready, awready, rdata, rresp, rvalid, rlast, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, arburst, arlen, arsize,
        input  awaddr, awvalid, awburst, awlen,
        input  rready, wdata, wstrb, wlast, wvalid, bready,
        output arready, awready, rdata, rresp, rvalid, rlast, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_full_m_line.sv
// rtl/axi_full_m_line.sv - cache-line AXI4 INCR burst master (refill / writeback)
module axi_full_m_line #(
    parameter int LINE_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [31:0]                req_addr,
    input  logic [64*LINE_WORDS-1:0]   req_wline,
    output logic                       resp_valid,
    output logic [64*LINE_WORDS-1:0]   resp_rline,
    output logic                       resp_err,
    axi_full_m_line_if.master          axi
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int CW = IW + 1;
    localparam int ADDR_LSB = $clog2(8 * LINE_WORDS);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << ADDR_LSB) - 32'd1);
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RESP} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [31:0]                addr;
    logic [CW-1:0]              cnt;
    logic                       err;
    logic [LINE_WORDS-1:0][63:0] line;
    logic [IW-1:0]              idx;
    logic                       last_beat;

    assign idx       = cnt[IW-1:0];
    assign last_beat = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An early rlast ends the refill just like the final beat does.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = req_wr ? AW : AR;
            AR:   if (axi.arready) state_nxt = R;
            R:    if (axi.rvalid && (last_beat || axi.rlast)) state_nxt = RESP;
            AW:   if (axi.awready) state_nxt = W;
            W:    if (axi.wready && last_beat) state_nxt = B;
            B:    if (axi.bvalid) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            cnt  <= '0;
            err  <= 1'b0;
            line <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr <= req_addr & ADDR_MASK;
                    cnt  <= '0;
                    err  <= 1'b0;
                    if (req_wr) line <= req_wline;
                end
                R: if (axi.rvalid) begin
                    line[idx] <= axi.rdata;
                    cnt       <= cnt + 1'b1;
                    if (axi.rresp != 2'b00 || axi.rlast != last_beat) err <= 1'b1;
                end
                W: if (axi.wready) cnt <= cnt + 1'b1;
                B: if (axi.bvalid && axi.bresp != 2'b00) err <= 1'b1;
                default: ;
            endcase
        end
    end

    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign resp_err    = (state == RESP) && err;
    assign resp_rline  = line;

    assign axi.araddr  = addr;
    assign axi.arvalid = (state == AR);
    assign axi.arburst = 2'b01;
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = 3'd3;

    assign axi.awaddr  = addr;
    assign axi.awvalid = (state == AW);
    assign axi.awburst = 2'b01;
    assign axi.awlen   = 8'(LINE_WORDS - 1);

    assign axi.rready  = (state == R);
    assign axi.wdata   = line[idx];
    assign axi.wstrb   = 8'hFF;
    assign axi.wlast   = (state == W) && last_beat;
    assign axi.wvalid  = (state == W);
    assign axi.bready  = (state == B);
endmodule

// File: tb/tb_axi_full_m_line.sv
// tb/tb_axi_full_m_line.sv - scoreboard bench for the cache-line AXI4 burst master
module tb_axi_full_m_line;
    localparam int LINE_WORDS = 4;
    localparam int LW = 64 * LINE_WORDS;
    localparam int TIMEOUT = 200;
    localparam int N_RANDOM = 60;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_wr = 1'b0;
    logic [31:0]     req_addr = '0;
    logic [LW-1:0]   req_wline = '0;
    logic            resp_valid;
    logic [LW-1:0]   resp_rline;
    logic            resp_err;

    axi_full_m_line_if axi();

    axi_full_m_line #(.LINE_WORDS(LINE_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wline  (req_wline),
        .resp_valid (resp_valid),
        .resp_rline (resp_rline),
        .resp_err   (resp_err),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic                        wr;
        logic [31:0]                 raw_addr;
        logic [LINE_WORDS-1:0][63:0] data;
        int                          ar_wait;
        int                          aw_wait;
        int                          b_wait;
        int                          beat_mode;
        int                          nbeats;
        int                          rlast_beat;
        int                          rerr_beat;
        logic [1:0]                  rerr_val;
        logic [1:0]                  bresp;
        int                          rst_beat;
    } cfg_t;

    typedef struct {
        logic          wr;
        logic          err;
        logic [LW-1:0] rline;
        int            acc_cyc;
        int            lat;
    } exp_resp_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_w_t;

    cfg_t        cfg_q[$];
    exp_resp_t   exp_resp_q[$];
    exp_w_t      exp_w_q[$];
    logic [31:0] exp_ar_q[$];
    logic [31:0] exp_aw_q[$];
    logic [LW-1:0] model_line = '0;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endfunction

    function automatic void report();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic cfg_t base_cfg(input logic wr, input logic [31:0] raw);
        cfg_t c;
        c.wr = wr;
        c.raw_addr = raw;
        for (int i = 0; i < LINE_WORDS; i++) c.data[i] = {$urandom(), $urandom()};
        c.ar_wait = 0;
        c.aw_wait = 0;
        c.b_wait = 0;
        c.beat_mode = 0;
        c.nbeats = LINE_WORDS;
        c.rlast_beat = LINE_WORDS - 1;
        c.rerr_beat = -1;
        c.rerr_val = 2'b00;
        c.bresp = 2'b00;
        c.rst_beat = -1;
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c = base_cfg(1'($urandom_range(0, 1)), $urandom());
        c.ar_wait = int'($urandom_range(0, 3));
        c.aw_wait = int'($urandom_range(0, 3));
        c.b_wait = int'($urandom_range(0, 3));
        c.beat_mode = int'($urandom_range(0, 2));
        case ($urandom_range(0, 7))
            0: begin
                c.rerr_beat = int'($urandom_range(0, LINE_WORDS - 1));
                c.rerr_val = 2'($urandom_range(1, 3));
            end
            1: begin
                c.rlast_beat = int'($urandom_range(0, LINE_WORDS - 2));
                c.nbeats = c.rlast_beat + 1;
            end
            2: c.rlast_beat = -1;
            3: c.bresp = 2'($urandom_range(1, 3));
            default: ;
        endcase
        return c;
    endfunction

    // Reference model: what the cache should see for a request described by c.
    function automatic void predict(input cfg_t c, input int lat);
        exp_resp_t e;
        exp_w_t w;
        logic [31:0] aligned;
        aligned = c.raw_addr - (c.raw_addr % (8 * LINE_WORDS));
        e.wr = c.wr;
        e.err = 1'b0;
        e.rline = '0;
        e.acc_cyc = cyc;
        e.lat = lat;
        if (c.wr) begin
            exp_aw_q.push_back(aligned);
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (c.rst_beat < 0 || i < c.rst_beat) begin
                    w.data = c.data[i];
                    w.last = (i == LINE_WORDS - 1);
                    exp_w_q.push_back(w);
                end
            end
            e.err = (c.bresp != 2'b00);
            model_line = c.data;
        end else begin
            exp_ar_q.push_back(aligned);
            for (int i = 0; i < c.nbeats; i++) begin
                model_line[64*i +: 64] = c.data[i];
                if (i == c.rerr_beat) e.err = 1'b1;
            end
            if (c.rlast_beat != LINE_WORDS - 1) e.err = 1'b1;
            e.rline = model_line;
        end
        if (c.rst_beat < 0) exp_resp_q.push_back(e);
    endfunction

    task automatic issue(input cfg_t c, input int lat, input bit hold);
        int t;
        req_wr = c.wr;
        req_addr = c.raw_addr;
        req_wline = c.data;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < TIMEOUT) begin
            step();
            t++;
        end
        if (t >= TIMEOUT) fail("req_ready timeout");
        chk("accept_after_resp", LW'(exp_resp_q.size()), LW'(0));
        predict(c, lat);
        cfg_q.push_back(c);
        step();
        if (!hold) req_valid = 1'b0;
    endtask

    function automatic int beat_delay(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic serve(input cfg_t c);
        int t;
        t = 0;
        if (!c.wr) begin
            while (!axi.arvalid && t < TIMEOUT) begin step(); t++; end
            if (t >= TIMEOUT) fail("arvalid timeout");
            repeat (c.ar_wait) step();
            axi.arready = 1'b1;
            step();
            axi.arready = 1'b0;
            for (int b = 0; b < c.nbeats; b++) begin
                repeat (beat_delay(c.beat_mode)) step();
                axi.rvalid = 1'b1;
                axi.rdata = c.data[b];
                axi.rresp = (b == c.rerr_beat) ? c.rerr_val : 2'b00;
                axi.rlast = (b == c.rlast_beat);
                step();
                axi.rvalid = 1'b0;
                axi.rlast = 1'b0;
                axi.rresp = 2'b00;
            end
        end else begin
            while (!axi.awvalid && t < TIMEOUT) begin step(); t++; end
            if (t >= TIMEOUT) fail("awvalid timeout");
            repeat (c.aw_wait) step();
            axi.awready = 1'b1;
            step();
            axi.awready = 1'b0;
            for (int b = 0; b < LINE_WORDS; b++) begin
                if (c.rst_beat >= 0 && b >= c.rst_beat) break;
                repeat (beat_delay(c.beat_mode)) step();
                axi.wready = 1'b1;
                step();
                axi.wready = 1'b0;
            end
            if (c.rst_beat < 0) begin
                repeat (c.b_wait) step();
                axi.bvalid = 1'b1;
                axi.bresp = c.bresp;
                step();
                axi.bvalid = 1'b0;
                axi.bresp = 2'b00;
            end
        end
    endtask

    initial begin : slave
        cfg_t c;
        axi.arready = 1'b0;
        axi.awready = 1'b0;
        axi.rvalid = 1'b0;
        axi.rlast = 1'b0;
        axi.rdata = '0;
        axi.rresp = 2'b00;
        axi.wready = 1'b0;
        axi.bvalid = 1'b0;
        axi.bresp = 2'b00;
        forever begin
            step();
            if (cfg_q.size() != 0) begin
                c = cfg_q.pop_front();
                serve(c);
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_resp_t e;
        exp_w_t w;
        if (resp_valid) begin
            if (exp_resp_q.size() == 0) begin
                fail("unexpected resp_valid");
            end else begin
                e = exp_resp_q.pop_front();
                chk("resp_err", LW'(resp_err), LW'(e.err));
                if (!e.wr) chk("resp_rline", resp_rline, e.rline);
                if (e.lat >= 0) chk("resp_latency", LW'(cyc - e.acc_cyc), LW'(e.lat));
            end
        end
        if (axi.arvalid) begin
            if (exp_ar_q.size() == 0) begin
                fail("unexpected arvalid");
            end else begin
                chk("araddr", LW'(axi.araddr), LW'(exp_ar_q[0]));
                if (axi.arready) begin
                    chk("arlen", LW'(axi.arlen), LW'(LINE_WORDS - 1));
                    chk("arburst", LW'(axi.arburst), LW'(2'b01));
                    chk("arsize", LW'(axi.arsize), LW'(3'd3));
                    void'(exp_ar_q.pop_front());
                end
            end
        end
        if (axi.awvalid) begin
            if (exp_aw_q.size() == 0) begin
                fail("unexpected awvalid");
            end else begin
                chk("awaddr", LW'(axi.awaddr), LW'(exp_aw_q[0]));
                if (axi.awready) begin
                    chk("awlen", LW'(axi.awlen), LW'(LINE_WORDS - 1));
                    chk("awburst", LW'(axi.awburst), LW'(2'b01));
                    void'(exp_aw_q.pop_front());
                end
            end
        end
        if (axi.wvalid && exp_w_q.size() != 0) begin
            chk("wdata", LW'(axi.wdata), LW'(exp_w_q[0].data));
            if (axi.wready) begin
                w = exp_w_q.pop_front();
                chk("wlast", LW'(axi.wlast), LW'(w.last));
                chk("wstrb", LW'(axi.wstrb), LW'(8'hFF));
            end
        end
        if (axi.arready) chk("arvalid_with_arready", LW'(axi.arvalid), LW'(1));
        if (axi.awready) chk("awvalid_with_awready", LW'(axi.awvalid), LW'(1));
        if (axi.rvalid)  chk("rready_with_rvalid", LW'(axi.rready), LW'(1));
        if (axi.wready)  chk("wvalid_with_wready", LW'(axi.wvalid), LW'(1));
        if (axi.bvalid)  chk("bready_with_bvalid", LW'(axi.bready), LW'(1));
    end

    initial begin : watchdog
        #500000;
        fail("watchdog expired");
        report();
        $finish;
    end

    initial begin : stimulus
        cfg_t c;
        int t;
        repeat (3) step();
        @(negedge clk);
        chk("rst_req_ready", LW'(req_ready), LW'(1));
        chk("rst_arvalid", LW'(axi.arvalid), LW'(0));
        chk("rst_awvalid", LW'(axi.awvalid), LW'(0));
        chk("rst_rready", LW'(axi.rready), LW'(0));
        chk("rst_wvalid", LW'(axi.wvalid), LW'(0));
        chk("rst_wlast", LW'(axi.wlast), LW'(0));
        chk("rst_bready", LW'(axi.bready), LW'(0));
        chk("rst_resp_valid", LW'(resp_valid), LW'(0));
        chk("rst_resp_err", LW'(resp_err), LW'(0));
        chk("rst_line", resp_rline, LW'(0));
        step();
        rst = 1'b0;
        step();

        c = base_cfg(1'b0, 32'h8000_001C);
        c.data[0] = 64'h1111_1111_1111_1111;
        c.data[1] = 64'h2222_2222_2222_2222;
        c.data[2] = 64'h3333_3333_3333_3333;
        c.data[3] = 64'h4444_4444_4444_4444;
        issue(c, LINE_WORDS + 2, 1'b0);

        c = base_cfg(1'b1, 32'h8000_0040);
        c.data[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        c.data[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        c.data[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        c.data[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        c.beat_mode = 1;
        issue(c, -1, 1'b0);

        c = base_cfg(1'b1, 32'h1234_5678);
        issue(c, LINE_WORDS + 3, 1'b0);

        c = base_cfg(1'b0, 32'h0000_0100);
        c.rerr_beat = 2;
        c.rerr_val = 2'b10;
        issue(c, LINE_WORDS + 2, 1'b0);

        c = base_cfg(1'b0, 32'h0000_0200);
        c.rlast_beat = 1;
        c.nbeats = 2;
        issue(c, 4, 1'b0);

        c = base_cfg(1'b1, 32'h0000_0300);
        c.bresp = 2'b01;
        issue(c, LINE_WORDS + 3, 1'b0);

        c = base_cfg(1'b0, 32'h4000_0ABC);
        c.ar_wait = 5;
        issue(c, LINE_WORDS + 7, 1'b1);
        c = base_cfg(1'b0, 32'h4000_1000);
        issue(c, -1, 1'b0);

        c = base_cfg(1'b1, 32'h9000_0000);
        c.rst_beat = 2;
        issue(c, -1, 1'b0);
        t = 0;
        while (!(exp_w_q.size() == 0 && axi.wvalid) && t < TIMEOUT) begin
            step();
            t++;
        end
        if (t >= TIMEOUT) fail("reset test W stall timeout");
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_line = '0;
        @(negedge clk);
        chk("midrst_wvalid", LW'(axi.wvalid), LW'(0));
        chk("midrst_req_ready", LW'(req_ready), LW'(1));
        chk("midrst_resp_valid", LW'(resp_valid), LW'(0));
        chk("midrst_line", resp_rline, LW'(0));
        step();

        c = base_cfg(1'b0, 32'h0000_0040);
        issue(c, LINE_WORDS + 2, 1'b0);

        for (int n = 0; n < N_RANDOM; n++) begin
            c = rand_cfg();
            issue(c, -1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end
        req_valid = 1'b0;

        t = 0;
        while ((exp_resp_q.size() != 0 || cfg_q.size() != 0) && t < 20 * TIMEOUT) begin
            step();
            t++;
        end
        if (t >= 20 * TIMEOUT) fail("drain timeout");
        repeat (5) step();
        chk("leftover_resp", LW'(exp_resp_q.size()), LW'(0));
        chk("leftover_w", LW'(exp_w_q.size()), LW'(0));
        chk("leftover_ar", LW'(exp_ar_q.size()), LW'(0));
        chk("leftover_aw", LW'(exp_aw_q.size()), LW'(0));
        report();
        $finish;
    end
endmodule
